// File: rtl/r32i_pkg.sv
// Shared constants and index type for the RV32I integer register file.
package r32i_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file; x0 reads as zero.
// Write-through forwarding is compiled in when REG_BYPASS_EN is defined.
module regfile_read_port
  import r32i_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic [REG_COUNT-1:1][dataW-1:0] regs_i,
  input  reg_idx_t                        idx_i,
  input  logic                            byp_en_i,
  input  reg_idx_t                        byp_idx_i,
  input  logic [dataW-1:0]                byp_data_i,
  output logic [dataW-1:0]                data_o
);

  always_comb begin
    data_o = '0;
    if (idx_i != ZERO_REG) data_o = regs_i[idx_i];
`ifdef REG_BYPASS_EN
    // Forward the in-flight write so the consumer sees it this cycle.
    if (byp_en_i && (byp_idx_i == idx_i) && (idx_i != ZERO_REG)) data_o = byp_data_i;
`endif
  end

`ifndef REG_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_en_i, byp_idx_i, byp_data_i};
`endif

endmodule

// File: rtl/register_r32i.sv
// RV32I register file: x1-x31 storage, x0 hard-wired zero, 2 read / 1 write.
// Optional same-cycle write forwarding via the REG_BYPASS_EN macro.
module register_r32i
  import r32i_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             RegWriteControl,
  input  logic [dataW-1:0] RegDataIn,
  input  logic [dataW-1:0] RegWriteAddr,
  input  logic [dataW-1:0] RegData1,
  input  logic [dataW-1:0] RegData2,
  output logic [dataW-1:0] RegDataOut1,
  output logic [dataW-1:0] RegDataOut2
);

  localparam int NUM_RD = 2;

  logic [REG_COUNT-1:1][dataW-1:0] regs_q, regs_d;
  reg_idx_t                        wr_idx;
  logic                            byp_en;
  logic [NUM_RD-1:0][REG_ADDR_W-1:0] rd_idx;
  logic [NUM_RD-1:0][dataW-1:0]      rd_data;

  // Only the low index bits select a register; higher addresses alias.
  assign wr_idx = RegWriteAddr[REG_ADDR_W-1:0];
  assign rd_idx = {RegData2[REG_ADDR_W-1:0], RegData1[REG_ADDR_W-1:0]};
  assign byp_en = RegWriteControl && !reset;

  always_comb begin
    regs_d = regs_q;
    if (RegWriteControl && (wr_idx != ZERO_REG)) regs_d[wr_idx] = RegDataIn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(.dataW(dataW)) u_rd (
      .regs_i    (regs_q),
      .idx_i     (rd_idx[p]),
      .byp_en_i  (byp_en),
      .byp_idx_i (wr_idx),
      .byp_data_i(RegDataIn),
      .data_o    (rd_data[p])
    );
  end

  assign RegDataOut1 = rd_data[0];
  assign RegDataOut2 = rd_data[1];

  if (dataW > REG_ADDR_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{RegWriteAddr[dataW-1:REG_ADDR_W],
                         RegData1[dataW-1:REG_ADDR_W],
                         RegData2[dataW-1:REG_ADDR_W]};
  end

endmodule

// File: tb/tb_register_r32i.sv
// Scoreboard bench for register_r32i: stimulus queues expected read data,
// a monitor pops and compares on each sample event.
module tb_register_r32i;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        RegWriteControl;
  logic [31:0] RegDataIn, RegWriteAddr, RegData1, RegData2;
  logic [31:0] RegDataOut1, RegDataOut2;

  register_r32i #(.dataW(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .RegWriteControl(RegWriteControl),
    .RegDataIn      (RegDataIn),
    .RegWriteAddr   (RegWriteAddr),
    .RegData1       (RegData1),
    .RegData2       (RegData2),
    .RegDataOut1    (RegDataOut1),
    .RegDataOut2    (RegDataOut2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       tag;
  } exp_t;

  exp_t q[$];
  event smp_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares the DUT outputs against every queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(smp_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (RegDataOut1 !== e.e1) begin
          errors++;
          $display("FAIL %s out1: got %h expected %h", e.tag, RegDataOut1, e.e1);
        end
        checks++;
        if (RegDataOut2 !== e.e2) begin
          errors++;
          $display("FAIL %s out2: got %h expected %h", e.tag, RegDataOut2, e.e2);
        end
      end
    end
  end

  task automatic expect_out(input logic [31:0] e1, input logic [31:0] e2, input string tag);
    exp_t e;
    e.e1 = e1; e.e2 = e2; e.tag = tag;
    q.push_back(e);
    #1;
    -> smp_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic en, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] r1, input logic [31:0] r2);
    RegWriteControl = en;
    RegWriteAddr    = wa;
    RegDataIn       = wd;
    RegData1        = r1;
    RegData2        = r2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd5);
    #1;
    expect_out(32'd0, 32'd0, "rst_hold");
    tick();
    reset = 1'b0;
    expect_out(32'd0, 32'd0, "post_rst");

    // x1 <- 897
    drive(1'b1, 32'd1, 32'd897, 32'd1, 32'd0);
    expect_out(BYP ? 32'd897 : 32'd0, 32'd0, "pre_w1");
    tick();
    RegWriteControl = 1'b0;
    expect_out(32'd897, 32'd0, "w1");

    // x2 <- 666 while reading x1/x2
    drive(1'b1, 32'd2, 32'd666, 32'd1, 32'd2);
    expect_out(32'd897, BYP ? 32'd666 : 32'd0, "pre_w2");
    tick();
    RegWriteControl = 1'b0;
    expect_out(32'd897, 32'd666, "w2");

    // Write to x0 is discarded and never forwarded
    drive(1'b1, 32'd0, 32'd666, 32'd0, 32'd0);
    expect_out(32'd0, 32'd0, "pre_x0");
    tick();
    RegWriteControl = 1'b0;
    expect_out(32'd0, 32'd0, "x0");

    // Disabled writes over two clocks
    drive(1'b0, 32'd2, 32'd65, 32'd1, 32'd2);
    expect_out(32'd897, 32'd666, "pre_hold");
    tick();
    tick();
    expect_out(32'd897, 32'd666, "hold");

    // Aliased addresses: 35 -> x3, read via 67 -> x3
    drive(1'b1, 32'd35, 32'hDEADBEEF, 32'd67, 32'd1);
    expect_out(BYP ? 32'hDEADBEEF : 32'd0, 32'd897, "pre_alias");
    tick();
    RegWriteControl = 1'b0;
    expect_out(32'hDEADBEEF, 32'd897, "alias");

    // Top register, both ports on it
    drive(1'b1, 32'd31, 32'hFFFFFFFF, 32'd31, 32'd31);
    expect_out(BYP ? 32'hFFFFFFFF : 32'd0, BYP ? 32'hFFFFFFFF : 32'd0, "pre_x31");
    tick();
    RegWriteControl = 1'b0;
    expect_out(32'hFFFFFFFF, 32'hFFFFFFFF, "x31");

    // Asynchronous reset mid-cycle, with a write edge during reset
    drive(1'b0, 32'd0, 32'd0, 32'd1, 32'd2);
    expect_out(32'd897, 32'd666, "pre_rst");
    reset = 1'b1;
    expect_out(32'd0, 32'd0, "rst_async");
    drive(1'b1, 32'd3, 32'h12345678, 32'd3, 32'd31);
    expect_out(32'd0, 32'd0, "rst_wr_blk");
    tick();
    expect_out(32'd0, 32'd0, "rst_edge");
    RegWriteControl = 1'b0;
    reset = 1'b0;
    expect_out(32'd0, 32'd0, "rst_cleared");

    // First write after reset release lands on the next edge
    drive(1'b1, 32'd4, 32'h55, 32'd4, 32'd2);
    expect_out(BYP ? 32'h55 : 32'd0, 32'd0, "pre_first_w");
    tick();
    RegWriteControl = 1'b0;
    expect_out(32'h55, 32'd0, "first_w");

    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
